// File: rtl/uart_pkg.sv
// Shared definitions for the UART sender: FSM state encoding and parity modes.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_fifo.sv
// Circular-buffer TX FIFO. Pushes while full and pops while empty are ignored,
// so a blocked write never disturbs the stored words.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_baud,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk_baud or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_baud) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_sender_fifo.sv
// Buffered UART transmitter: words queue in a small FIFO and are serialised
// back to back as start / data (LSB first) / optional parity / stop bits.
module uart_sender_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int CLK_PER_BIT = 16,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk_baud,
  input  logic                          reset,
  // Handshake: a word is accepted at each rising edge where tx_en and
  // tx_ready are both high; a write while tx_ready is low is discarded.
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_en,
  output logic                          tx_ready,
  output logic                          tx_status,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  output logic                          uart_tx,
  output tx_state_t                     state_dbg
);

  localparam int TW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int LT = CLK_PER_BIT - 1;
  localparam int LD = DATA_BITS - 1;
  localparam int LS = STOP_BITS - 1;
  localparam logic [TW-1:0] LAST_TICK = LT[TW-1:0];
  localparam logic [2:0]    LAST_DATA = LD[2:0];
  localparam logic          LAST_STOP = LS[0];

  tx_state_t            state, state_d;
  logic [TW-1:0]        timer, timer_d;
  logic [2:0]           bit_cnt, bit_d;
  logic                 stop_cnt, stop_d;
  logic [DATA_BITS-1:0] shreg, sh_d;
  logic                 par_bit, par_d;
  logic                 tx_q, tx_d;
  logic                 bit_end;
  logic                 load;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_baud (clk_baud),
    .reset    (reset),
    .push     (tx_en),
    .pop      (load),
    .wdata    (tx_data),
    .rdata    (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (tx_count)
  );

  assign tx_ready  = ~fifo_full;
  assign tx_status = fifo_empty && (state == ST_IDLE);
  assign uart_tx   = tx_q;
  assign state_dbg = state;
  assign bit_end   = (timer == LAST_TICK);
  // A new frame starts from IDLE, or straight out of the last stop bit.
  assign load      = ~fifo_empty &&
                     ((state == ST_IDLE) ||
                      (state == ST_STOP && bit_end && stop_cnt == LAST_STOP));

  always_ff @(posedge clk_baud or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_d;
      timer    <= timer_d;
      bit_cnt  <= bit_d;
      stop_cnt <= stop_d;
      shreg    <= sh_d;
      par_bit  <= par_d;
      tx_q     <= tx_d;
    end
  end

  always_comb begin
    state_d = state;
    timer_d = timer;
    bit_d   = bit_cnt;
    stop_d  = stop_cnt;
    sh_d    = shreg;
    par_d   = par_bit;
    tx_d    = tx_q;
    if (state != ST_IDLE && !bit_end) timer_d = timer + 1'b1;
    case (state)
      ST_IDLE: ;
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          timer_d = '0;
          bit_d   = '0;
          tx_d    = shreg[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          timer_d = '0;
          if (bit_cnt == LAST_DATA) begin
            if (PARITY != PAR_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_bit;
            end else begin
              state_d = ST_STOP;
              stop_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_cnt + 1'b1;
            sh_d  = shreg >> 1;
            tx_d  = shreg[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          timer_d = '0;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          timer_d = '0;
          if (stop_cnt == LAST_STOP) begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    // Parity is latched with the word so the shifting register can be consumed.
    if (load) begin
      state_d = ST_START;
      timer_d = '0;
      sh_d    = fifo_rdata;
      par_d   = (^fifo_rdata) ^ (PARITY == PAR_ODD);
      tx_d    = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_sender_fifo.sv
// Bench for uart_sender_fifo: four configurations run side by side, each
// tracked every cycle by a frame-level model, plus directed vectors and sequences.
module tb_uart_sender_fifo;
  import uart_pkg::*;

  logic        clk_baud;
  logic        reset;
  logic [7:0]  tdata [4];
  logic [3:0]  ten;
  logic [3:0]  ready;
  logic [3:0]  status;
  logic [3:0]  line;
  logic [2:0]  cnt [4];
  tx_state_t   st_dbg [4];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int   inst;
    int   k;
    logic tx;
    logic status;
  } vec_t;
  vec_t vecs[$];

  logic [7:0] exp_q[$];

  function automatic int cfg_db(input int g);
    return (g == 3) ? 5 : 8;
  endfunction
  function automatic int cfg_cpb(input int g);
    return (g == 3) ? 4 : 16;
  endfunction
  function automatic int cfg_par(input int g);
    return (g == 1) ? 1 : (g == 2) ? 2 : 0;
  endfunction
  function automatic int cfg_sb(input int g);
    return (g == 3) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial clk_baud = 1'b0;
  always #5 clk_baud = ~clk_baud;

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int DB  = cfg_db(g);
    localparam int CPB = cfg_cpb(g);
    localparam int PAR = cfg_par(g);
    localparam int SB  = cfg_sb(g);
    localparam int LEN = (1 + DB + ((PAR != 0) ? 1 : 0) + SB) * CPB;

    uart_sender_fifo #(
      .DATA_BITS   (DB),
      .CLK_PER_BIT (CPB),
      .PARITY      (PAR),
      .STOP_BITS   (SB),
      .FIFO_DEPTH  (4)
    ) dut (
      .clk_baud  (clk_baud),
      .reset     (reset),
      .tx_data   (tdata[g][DB-1:0]),
      .tx_en     (ten[g]),
      .tx_ready  (ready[g]),
      .tx_status (status[g]),
      .tx_count  (cnt[g]),
      .uart_tx   (line[g]),
      .state_dbg (st_dbg[g])
    );

    // Model: queued words, plus the current frame as a list of line bits and
    // the number of clock cycles left in it.
    int   fq[$];
    int   rem = 0;
    logic fbits [16];
    int   word;
    int   ones;
    logic pop_now;
    logic push_now;
    logic exp_line;

    always @(posedge clk_baud or posedge reset) begin
      if (reset) begin
        fq.delete();
        rem = 0;
      end else begin
        pop_now  = (fq.size() > 0) && (rem <= 1);
        push_now = ten[g] && (fq.size() < 4);
        if (rem > 0) rem = rem - 1;
        if (pop_now) begin
          word = fq.pop_front();
          ones = 0;
          for (int i = 0; i < 16; i++) fbits[i] = 1'b1;
          fbits[0] = 1'b0;
          for (int i = 0; i < DB; i++) begin
            fbits[1+i] = 1'((word >> i) & 1);
            ones += (word >> i) & 1;
          end
          if (PAR != 0) fbits[1+DB] = 1'((ones % 2) == 1) ^ 1'(PAR == 2);
          rem = LEN;
        end
        if (push_now) fq.push_back(int'(tdata[g]) % (1 << DB));
      end
    end

    always @(negedge clk_baud) begin
      exp_line = (rem == 0) ? 1'b1 : fbits[(LEN - rem) / CPB];
      chk($sformatf("cfg%0d line", g), 32'(line[g]), 32'(exp_line));
      chk($sformatf("cfg%0d ready", g), 32'(ready[g]), 32'(fq.size() < 4));
      chk($sformatf("cfg%0d status", g), 32'(status[g]), 32'(fq.size() == 0 && rem == 0));
      chk($sformatf("cfg%0d count", g), 32'(cnt[g]), 32'(fq.size()));
      chk($sformatf("cfg%0d idle_state", g), 32'(st_dbg[g] == ST_IDLE), 32'(rem == 0));
    end
  end

  initial begin
    logic [7:0] pushes [6];
    int         cnt_exp [6];
    logic [7:0] rx;
    int         j;
    int         off;

    vecs.push_back('{0, 0,   1'b1, 1'b0});
    vecs.push_back('{0, 1,   1'b0, 1'b0});
    vecs.push_back('{0, 16,  1'b0, 1'b0});
    vecs.push_back('{0, 17,  1'b1, 1'b0});
    vecs.push_back('{0, 33,  1'b0, 1'b0});
    vecs.push_back('{0, 48,  1'b0, 1'b0});
    vecs.push_back('{0, 49,  1'b1, 1'b0});
    vecs.push_back('{0, 129, 1'b0, 1'b0});
    vecs.push_back('{0, 144, 1'b0, 1'b0});
    vecs.push_back('{0, 145, 1'b1, 1'b0});
    vecs.push_back('{0, 160, 1'b1, 1'b0});
    vecs.push_back('{0, 161, 1'b1, 1'b1});
    vecs.push_back('{1, 144, 1'b0, 1'b0});
    vecs.push_back('{1, 145, 1'b1, 1'b0});
    vecs.push_back('{1, 160, 1'b1, 1'b0});
    vecs.push_back('{1, 176, 1'b1, 1'b0});
    vecs.push_back('{1, 177, 1'b1, 1'b1});
    vecs.push_back('{2, 144, 1'b0, 1'b0});
    vecs.push_back('{2, 145, 1'b0, 1'b0});
    vecs.push_back('{2, 160, 1'b0, 1'b0});
    vecs.push_back('{2, 161, 1'b1, 1'b0});
    vecs.push_back('{2, 176, 1'b1, 1'b0});
    vecs.push_back('{2, 177, 1'b1, 1'b1});
    vecs.push_back('{3, 1,   1'b0, 1'b0});
    vecs.push_back('{3, 4,   1'b0, 1'b0});
    vecs.push_back('{3, 5,   1'b1, 1'b0});
    vecs.push_back('{3, 24,  1'b1, 1'b0});
    vecs.push_back('{3, 32,  1'b1, 1'b0});
    vecs.push_back('{3, 33,  1'b1, 1'b1});

    reset = 1'b1;
    ten   = '0;
    for (int g = 0; g < 4; g++) tdata[g] = '0;
    repeat (3) @(negedge clk_baud);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("reset line %0d", g), 32'(line[g]), 32'd1);
      chk($sformatf("reset ready %0d", g), 32'(ready[g]), 32'd1);
      chk($sformatf("reset status %0d", g), 32'(status[g]), 32'd1);
      chk($sformatf("reset count %0d", g), 32'(cnt[g]), 32'd0);
    end
    #2 reset = 1'b0;

    // Single frames on every configuration, checked against the vector table.
    @(negedge clk_baud);
    tdata[0] = 8'h55; tdata[1] = 8'h07; tdata[2] = 8'h07; tdata[3] = 8'h1F;
    ten = 4'hF;
    @(negedge clk_baud);
    ten = '0;
    for (int k = 0; k <= 180; k++) begin
      foreach (vecs[i]) begin
        if (vecs[i].k == k) begin
          chk($sformatf("vec cfg%0d k%0d tx", vecs[i].inst, k), 32'(line[vecs[i].inst]), 32'(vecs[i].tx));
          chk($sformatf("vec cfg%0d k%0d status", vecs[i].inst, k), 32'(status[vecs[i].inst]), 32'(vecs[i].status));
        end
      end
      @(negedge clk_baud);
    end

    // Burst into a busy sender: primer word occupies the line, four words fill
    // the FIFO, the sixth write finds it full and is dropped.
    pushes  = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    cnt_exp = '{1, 1, 2, 3, 4, 4};
    exp_q   = {8'hA5, 8'h11, 8'h22, 8'h33, 8'h44};
    rx = '0;
    tdata[0] = pushes[0];
    ten[0]   = 1'b1;
    @(negedge clk_baud);
    for (int k = 0; k <= 805; k++) begin
      if (k <= 5) begin
        chk($sformatf("burst count k%0d", k), 32'(cnt[0]), 32'(cnt_exp[k]));
        chk($sformatf("burst ready k%0d", k), 32'(ready[0]), 32'(k < 4));
        if (k < 5) tdata[0] = pushes[k+1];
        else       ten[0] = 1'b0;
      end
      j   = (k - 1) / 160;
      off = (k - 1) % 160;
      if (k >= 1 && j < 5) begin
        if (off == 0) begin
          chk($sformatf("burst start f%0d", j), 32'(line[0]), 32'd0);
          rx = '0;
        end
        if (off >= 16 && off < 144 && ((off - 16) % 16) == 8) rx[(off - 16) / 16] = line[0];
        if (off == 159) begin
          chk($sformatf("burst stop f%0d", j), 32'(line[0]), 32'd1);
          if (exp_q.size() > 0) chk($sformatf("burst word f%0d", j), 32'(rx), 32'(exp_q.pop_front()));
        end
      end
      if (k == 801) chk("burst final status", 32'(status[0]), 32'd1);
      @(negedge clk_baud);
    end
    chk("burst words left", 32'(exp_q.size()), 32'd0);

    // Reset in the third data bit with two words still queued.
    tdata[0] = 8'h00;
    ten[0]   = 1'b1;
    @(negedge clk_baud);
    tdata[0] = 8'hC3;
    @(negedge clk_baud);
    tdata[0] = 8'h3C;
    @(negedge clk_baud);
    ten[0] = 1'b0;
    chk("abort queued", 32'(cnt[0]), 32'd2);
    repeat (54) @(negedge clk_baud);
    chk("abort bit2 low", 32'(line[0]), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("abort line", 32'(line[0]), 32'd1);
    chk("abort count", 32'(cnt[0]), 32'd0);
    chk("abort status", 32'(status[0]), 32'd1);
    chk("abort ready", 32'(ready[0]), 32'd1);
    @(negedge clk_baud);
    #2 reset = 1'b0;
    @(negedge clk_baud);
    tdata[0] = 8'h96;
    ten[0]   = 1'b1;
    @(negedge clk_baud);
    ten[0] = 1'b0;
    chk("post-abort status fall", 32'(status[0]), 32'd0);
    for (int k = 1; k <= 170; k++) begin
      @(negedge clk_baud);
      off = k - 1;
      if (off == 0) rx = '0;
      if (off >= 16 && off < 144 && ((off - 16) % 16) == 8) rx[(off - 16) / 16] = line[0];
      if (off == 159) chk("post-abort word", 32'(rx), 32'h96);
      if (k == 161 || k == 170) begin
        chk($sformatf("post-abort idle k%0d", k), 32'(status[0]), 32'd1);
        chk($sformatf("post-abort line k%0d", k), 32'(line[0]), 32'd1);
      end
    end

    // Random traffic with alternating light and heavy load and rare resets.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk_baud);
      if (reset)                               #2 reset = 1'b0;
      else if ($urandom_range(0, 1999) == 0)  #2 reset = 1'b1;
      for (int g = 0; g < 4; g++) begin
        ten[g]   = ($urandom_range(0, 99) < (((cyc / 500) % 2 == 1) ? 30 : 3));
        tdata[g] = 8'($urandom_range(0, 255));
      end
    end
    @(negedge clk_baud);
    ten = '0;
    #2 reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (&status) break;
      @(negedge clk_baud);
    end
    chk("drain idle", 32'(status), 32'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
